// File: rtl/bus_arbiter.sv
// Two-master (CPU/DMA) round-robin arbiter for the shared peripheral bus.
// Sequences IDLE -> ACCESS -> DONE and handles region decode, wait states and error responses.
module bus_arbiter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        m0_req,
    input  logic        m1_req,
    input  logic        m0_we,
    input  logic        m1_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m0_wdata,
    input  logic [31:0] m1_wdata,
    output logic        m0_ack,
    output logic        m1_ack,
    output logic        m0_err,
    output logic        m1_err,
    output logic [31:0] rdata,
    output logic        bus_en,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t      state_q;
    logic [1:0]  cnt_q;
    logic        last_q;      // 1 = m1 was granted last
    logic        gnt_q;       // 1 = m1 owns the current access
    logic        we_q;
    logic        illegal_q;
    logic        bus_en_q;
    logic        bus_we_q;
    logic [31:0] bus_addr_q;
    logic [31:0] bus_wdata_q;
    logic [31:0] rdata_q;
    logic        m0_ack_q;
    logic        m1_ack_q;
    logic        m0_err_q;
    logic        m1_err_q;

    logic        grant_m1_d;
    logic        win_we_d;
    logic [31:0] win_addr_d;
    logic [31:0] win_wdata_d;
    logic        legal_d;
    logic [1:0]  cnt_d;

    function automatic logic is_rom(input logic [31:0] a);
        return a[31:10] == 22'd0;
    endfunction

    function automatic logic is_ram(input logic [31:0] a);
        return a[31:8] == 24'h000004;
    endfunction

    function automatic logic is_io(input logic [31:0] a);
        return (a == 32'h0000_0500) || (a == 32'h0000_0504);
    endfunction

    // m1 wins alone, or on a tie when m0 held the previous grant.
    always_comb begin
        grant_m1_d  = m1_req & (~m0_req | ~last_q);
        win_we_d    = grant_m1_d ? m1_we    : m0_we;
        win_addr_d  = grant_m1_d ? m1_addr  : m0_addr;
        win_wdata_d = grant_m1_d ? m1_wdata : m0_wdata;
        legal_d     = (is_rom(win_addr_d) & ~win_we_d) | is_ram(win_addr_d) | is_io(win_addr_d);
        cnt_d       = is_io(win_addr_d) ? 2'd2 : 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= 2'd0;
            last_q      <= 1'b1;
            gnt_q       <= 1'b0;
            we_q        <= 1'b0;
            illegal_q   <= 1'b0;
            bus_en_q    <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= 32'd0;
            bus_wdata_q <= 32'd0;
            rdata_q     <= 32'd0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
            m0_err_q    <= 1'b0;
            m1_err_q    <= 1'b0;
        end else begin
            m0_ack_q <= 1'b0;
            m1_ack_q <= 1'b0;
            m0_err_q <= 1'b0;
            m1_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (m0_req | m1_req) begin
                        gnt_q       <= grant_m1_d;
                        last_q      <= grant_m1_d;
                        we_q        <= win_we_d;
                        illegal_q   <= ~legal_d;
                        bus_addr_q  <= win_addr_d;
                        bus_wdata_q <= win_wdata_d;
                        bus_en_q    <= legal_d;
                        bus_we_q    <= legal_d & win_we_d;
                        cnt_q       <= cnt_d;
                        state_q     <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (cnt_q == 2'd0) begin
                        rdata_q  <= (illegal_q | we_q) ? 32'd0 : bus_rdata;
                        bus_en_q <= 1'b0;
                        bus_we_q <= 1'b0;
                        state_q  <= DONE;
                    end else begin
                        cnt_q <= cnt_q - 2'd1;
                    end
                end
                DONE: begin
                    m0_ack_q <= ~gnt_q;
                    m1_ack_q <= gnt_q;
                    m0_err_q <= ~gnt_q & illegal_q;
                    m1_err_q <= gnt_q & illegal_q;
                    state_q  <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_err    = m0_err_q;
    assign m1_err    = m1_err_q;
    assign rdata     = rdata_q;
    assign bus_en    = bus_en_q;
    assign bus_we    = bus_we_q;
    assign bus_addr  = bus_addr_q;
    assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: latency, round-robin, wait states, errors and reset abort.
module tb_bus_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        m0_req = 1'b0, m1_req = 1'b0;
    logic        m0_we = 1'b0, m1_we = 1'b0;
    logic [31:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic        m0_ack, m1_ack, m0_err, m1_err;
    logic [31:0] rdata;
    logic        bus_en, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [31:0] bus_rdata = '0;

    int checks = 0;
    int errors = 0;

    bus_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .m0_req(m0_req), .m1_req(m1_req),
        .m0_we(m0_we), .m1_we(m1_we),
        .m0_addr(m0_addr), .m1_addr(m1_addr),
        .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
        .m0_ack(m0_ack), .m1_ack(m1_ack),
        .m0_err(m0_err), .m1_err(m1_err),
        .rdata(rdata),
        .bus_en(bus_en), .bus_we(bus_we),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_acks"}, 32'({m0_ack, m1_ack, m0_err, m1_err}), 32'd0);
        check({tag, "_bus_en"}, 32'({bus_en, bus_we}), 32'd0);
        check({tag, "_bus_addr"}, bus_addr, 32'd0);
        check({tag, "_bus_wdata"}, bus_wdata, 32'd0);
        check({tag, "_rdata"}, rdata, 32'd0);
    endtask

    initial begin
        // Reset state
        #1;
        rst_n = 1'b0;
        #2;
        check_all_zero("reset");
        step();
        rst_n = 1'b1;

        // m0 read from RAM 0x410
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0410;
        bus_rdata = 32'hDEAD_BEEF;
        step();
        check("ram_rd_en_k", 32'(bus_en), 32'd1);
        check("ram_rd_we_k", 32'(bus_we), 32'd0);
        check("ram_rd_addr", bus_addr, 32'h0000_0410);
        check("ram_rd_ack_k", 32'(m0_ack), 32'd0);
        step();
        check("ram_rd_en_k1", 32'(bus_en), 32'd0);
        check("ram_rd_ack_k1", 32'(m0_ack), 32'd0);
        step();
        check("ram_rd_ack", 32'(m0_ack), 32'd1);
        check("ram_rd_err", 32'(m0_err), 32'd0);
        check("ram_rd_m1ack", 32'(m1_ack), 32'd0);
        check("ram_rd_rdata", rdata, 32'hDEAD_BEEF);
        m0_req = 1'b0;
        step();
        check("ram_rd_ack_pulse", 32'(m0_ack), 32'd0);

        // Continuous tie after reset: m0, m1, m0, m1
        rst_n = 1'b0;
        #2;
        check_all_zero("reset2");
        step();
        rst_n = 1'b1;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0100;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0200;
        bus_rdata = 32'h1111_2222;
        for (int g = 0; g < 4; g++) begin
            for (int c = 0; c < 3; c++) begin
                step();
                check("rr_two_acks", 32'(m0_ack & m1_ack), 32'd0);
                if (c == 0)
                    check("rr_bus_addr", bus_addr, (g % 2 == 0) ? 32'h0000_0100 : 32'h0000_0200);
            end
            check("rr_m0_ack", 32'(m0_ack), (g % 2 == 0) ? 32'd1 : 32'd0);
            check("rr_m1_ack", 32'(m1_ack), (g % 2 == 1) ? 32'd1 : 32'd0);
        end

        // m1 write to UART 0x500: three wait cycles
        m0_req = 1'b0;
        m1_we = 1'b1; m1_addr = 32'h0000_0500; m1_wdata = 32'h0000_005A;
        bus_rdata = 32'h7777_7777;
        for (int c = 0; c < 3; c++) begin
            step();
            check("uart_wr_en", 32'({bus_en, bus_we}), 32'd3);
            check("uart_wr_addr", bus_addr, 32'h0000_0500);
            check("uart_wr_wdata", bus_wdata, 32'h0000_005A);
            check("uart_wr_ack_early", 32'(m1_ack), 32'd0);
        end
        step();
        check("uart_wr_en_off", 32'(bus_en), 32'd0);
        check("uart_wr_ack_k3", 32'(m1_ack), 32'd0);
        step();
        check("uart_wr_ack", 32'({m1_ack, m1_err, m0_ack}), 32'b100);
        check("uart_wr_rdata", rdata, 32'd0);

        // m0 write to ROM (illegal), then back-to-back read of unmapped 0x600
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b1; m0_addr = 32'h0000_0004; m0_wdata = 32'hFFFF_0000;
        bus_rdata = 32'h9999_AAAA;
        step();
        check("rom_wr_en", 32'({bus_en, bus_we}), 32'd0);
        step();
        check("rom_wr_en2", 32'(bus_en), 32'd0);
        step();
        check("rom_wr_ack_err", 32'({m0_ack, m0_err, m1_ack, m1_err}), 32'b1100);
        check("rom_wr_rdata", rdata, 32'd0);
        m0_we = 1'b0; m0_addr = 32'h0000_0600;
        step();
        check("unmap_en", 32'(bus_en), 32'd0);
        step();
        check("unmap_ack_early", 32'(m0_ack), 32'd0);
        step();
        check("unmap_ack_err", 32'({m0_ack, m0_err}), 32'b11);
        check("unmap_rdata", rdata, 32'd0);

        // m1 read from SR 0x504
        m0_req = 1'b0;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0504;
        bus_rdata = 32'hCAFE_0001;
        step();
        check("sr_rd_en", 32'({bus_en, bus_we}), 32'b10);
        step();
        step();
        step();
        check("sr_rd_ack_k3", 32'({bus_en, m1_ack}), 32'd0);
        step();
        check("sr_rd_ack", 32'({m1_ack, m1_err}), 32'b10);
        check("sr_rd_rdata", rdata, 32'hCAFE_0001);

        // Reset in the middle of a UART read
        m1_req = 1'b0;
        m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h0000_0500;
        step();
        check("abort_en", 32'(bus_en), 32'd1);
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check_all_zero("abort");
        m0_req = 1'b0;
        step();
        rst_n = 1'b1;
        for (int c = 0; c < 5; c++) begin
            step();
            check("abort_no_ack", 32'({m0_ack, m1_ack, bus_en}), 32'd0);
        end
        m0_req = 1'b1; m0_addr = 32'h0000_0430;
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h0000_0420;
        bus_rdata = 32'h1234_5678;
        step();
        check("abort_tie_addr", bus_addr, 32'h0000_0430);
        step();
        step();
        check("abort_tie_ack", 32'({m0_ack, m1_ack}), 32'b10);
        check("abort_tie_rdata", rdata, 32'h1234_5678);
        m0_req = 1'b0; m1_req = 1'b0;
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bus_arbiter.md
BUS_ARBITER -- requirements
Module: bus_arbiter

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock.
REQ-002 SHALL have: rst_n  input  1  asynchronous active-low reset.
REQ-003 SHALL have: m0_req, m1_req  input  1 each  master access request (m0 = CPU, m1 = DMA).
REQ-004 SHALL have: m0_we, m1_we  input  1 each  1 = write, 0 = read.
REQ-005 SHALL have: m0_addr, m1_addr  input  32 each  byte address.
REQ-006 SHALL have: m0_wdata, m1_wdata  input  32 each  write data.
REQ-007 SHALL have: m0_ack, m1_ack  output  1 each  one-cycle completion pulse.
REQ-008 SHALL have: m0_err, m1_err  output  1 each  error flag, valid only with ack.
REQ-009 SHALL have: rdata  output  32  read data to the acked master.
REQ-010 SHALL have: bus_en  output  1  shared-bus strobe to the address decoder.
REQ-011 SHALL have: bus_we  output  1  MemWrite to the address decoder.
REQ-012 SHALL have: bus_addr, bus_wdata  output  32 each  shared address and write data.
REQ-013 SHALL have: bus_rdata  input  32  muxed read data from ROM/RAM/UART/SR.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, DONE.
REQ-015 IDLE: on an edge with any req=1, SHALL latch the winner's we/addr/wdata and go to ACCESS; otherwise stay in IDLE.
REQ-016 Arbitration SHALL be round-robin: single requester wins; if both request, the master not granted last wins; last_grant updates on each grant.
REQ-017 Region decode on the latched address SHALL be: 0x000-0x3FF ROM, 0x400-0x4FF RAM, 0x500 UART, 0x504 SR; all other addresses are unmapped.
REQ-018 Wait count W SHALL be 1 for ROM/RAM/unmapped and 3 for UART/SR; a 2-bit counter SHALL be loaded with W-1 on entry to ACCESS.
REQ-019 ACCESS SHALL decrement the counter each edge; at the edge where the counter is 0 it SHALL capture bus_rdata into rdata and go to DONE.
REQ-020 DONE SHALL assert the granted master's ack for exactly one cycle, then return to IDLE; the next arbitration occurs in IDLE.
REQ-021 bus_en SHALL be 1 only in ACCESS for legal accesses; bus_we = latched we & bus_en; bus_addr/bus_wdata SHALL hold latched values throughout ACCESS.
REQ-022 An unmapped address, or a write to ROM, is illegal: bus_en stays 0, rdata is captured as 0, and err=1 with ack.
REQ-023 For legal accesses, err SHALL be 0; on writes, rdata SHALL be 0.
REQ-024 Latency: RAM/ROM read accepted at edge k SHALL produce ack in the cycle after edge k+2; UART/SR at edge k+4.
REQ-025 A master SHALL hold req and its fields until its ack; a req dropped mid-access SHALL NOT abort it (ack still pulses).
REQ-026 The non-granted master's ack/err SHALL stay 0; at most one ack SHALL be high in any cycle.
REQ-027 Back-to-back: a master holding req after its ack SHALL be rearbitrated in IDLE against the other master.

Reset
REQ-028 rst_n=0 SHALL immediately force state IDLE, counter 0, all acks/errs 0, bus_en 0, bus_we 0, and bus_addr/bus_wdata/rdata 0.
REQ-029 Reset SHALL set last_grant=m1, so m0 wins the first tie.
REQ-030 Reset asserted during ACCESS SHALL abandon the access with no ack after release.

Verification
REQ-031 Reset, then m0 read 0x0410 with bus_rdata=0xDEADBEEF -> bus_en high 1 cycle, m0_ack at edge k+2, rdata=0xDEADBEEF, err=0.
REQ-032 m0 and m1 request together continuously after reset -> grants alternate m0, m1, m0, m1; never two acks in one cycle.
REQ-033 m1 write to 0x0500 -> bus_en=bus_we=1 for 3 cycles, bus_addr=0x500, m1_ack at edge k+4.
REQ-034 m0 write to 0x0004 and m0 read 0x0600 -> bus_en stays 0, ack with err=1, rdata=0.
REQ-035 rst_n pulsed low mid-UART access -> outputs zero immediately, no ack afterwards, next tie goes to m0.
